// File: rtl/spi_frame_controller.sv
// SPI configuration frame controller: decodes an opcode byte, streams the payload into the
// register image, tracks per-target ready flags and presents a status byte for readback.
module spi_frame_controller #(
  parameter int unsigned M  = 320,
  parameter int unsigned N  = 8,
  parameter int unsigned AW = 9
) (
  input  logic          SCLK,
  input  logic          RESET,
  input  logic          SS,
  input  logic          rx_valid,
  input  logic [N-1:0]  rx_byte,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [N-1:0]  wr_data,
  output logic          clk_div_ready_reg_out,
  output logic          debug_config_ready_reg_out,
  output logic          input_spike_ready_reg_out,
  output logic [N-1:0]  tx_byte,
  output logic          busy
);

  localparam logic [AW-1:0] SpikeLen = AW'(M - 2);
  localparam logic [AW-1:0] LastAddr = AW'(M - 1);

  localparam logic [N-1:0] OpClkdiv = N'(8'hA1);
  localparam logic [N-1:0] OpDebug  = N'(8'hA2);
  localparam logic [N-1:0] OpSpike  = N'(8'hA3);
  localparam logic [N-1:0] OpStatus = N'(8'hA4);

  typedef enum logic [1:0] {StIdle, StData, StDiscard, StStatus} state_e;
  typedef enum logic [1:0] {TgtClkdiv, TgtDebug, TgtSpike} target_e;

  state_e        state_q, state_d;
  target_e       target_q, target_d;
  logic [AW-1:0] count_q, count_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [N-1:0]  wr_data_q, wr_data_d;
  logic [2:0]    rdy_q, rdy_d;  // {spike, debug, clkdiv}
  logic          err_q, err_d;
  logic [N-1:0]  tx_q, tx_d;

  logic [AW-1:0] base;
  logic [AW-1:0] len;
  logic [AW:0]   addr_sum;
  logic [AW-1:0] addr_sat;

  always_comb begin
    base = '0;
    len  = AW'(1);
    case (target_q)
      TgtDebug: base = AW'(1);
      TgtSpike: begin
        base = AW'(2);
        len  = SpikeLen;
      end
      default: ;
    endcase
  end

  // Clamp keeps the image address inside the M-byte window whatever the counter holds.
  always_comb begin
    addr_sum = {1'b0, base} + {1'b0, count_q};
    if (addr_sum > {1'b0, LastAddr}) begin
      addr_sat = LastAddr;
    end else begin
      addr_sat = addr_sum[AW-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rdy_d     = rdy_q;
    err_d     = err_q;
    tx_d      = tx_q;

    // The status byte was loaded on entry, so err is consumed on the following edge.
    if (state_q == StStatus) begin
      err_d = 1'b0;
    end

    if (SS) begin
      state_d = StIdle;
      if (state_q == StData) begin
        err_d = 1'b1;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (rx_valid) begin
            case (rx_byte)
              OpClkdiv: begin
                target_d = TgtClkdiv;
                rdy_d[0] = 1'b0;
                count_d  = '0;
                state_d  = StData;
              end
              OpDebug: begin
                target_d = TgtDebug;
                rdy_d[1] = 1'b0;
                count_d  = '0;
                state_d  = StData;
              end
              OpSpike: begin
                target_d = TgtSpike;
                rdy_d[2] = 1'b0;
                count_d  = '0;
                state_d  = StData;
              end
              OpStatus: begin
                tx_d    = N'({4'b0000, err_q, rdy_q[2], rdy_q[1], rdy_q[0]});
                state_d = StStatus;
              end
              default: begin
                err_d   = 1'b1;
                state_d = StDiscard;
              end
            endcase
          end
        end
        StData: begin
          if (rx_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_sat;
            wr_data_d = rx_byte;
            if (count_q != '1) begin
              count_d = count_q + AW'(1);
            end
            if (count_q >= len - AW'(1)) begin
              case (target_q)
                TgtClkdiv: rdy_d[0] = 1'b1;
                TgtDebug:  rdy_d[1] = 1'b1;
                TgtSpike:  rdy_d[2] = 1'b1;
                default: ;
              endcase
              state_d = StDiscard;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge SCLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      target_q  <= TgtClkdiv;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rdy_q     <= '0;
      err_q     <= 1'b0;
      tx_q      <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
      tx_q      <= tx_d;
    end
  end

  assign wr_en                      = wr_en_q;
  assign wr_addr                    = wr_addr_q;
  assign wr_data                    = wr_data_q;
  assign clk_div_ready_reg_out      = rdy_q[0];
  assign debug_config_ready_reg_out = rdy_q[1];
  assign input_spike_ready_reg_out  = rdy_q[2];
  assign tx_byte                    = tx_q;
  assign busy                       = (state_q != StIdle);

endmodule

// File: tb/tb_spi_frame_controller.sv
// Bench for spi_frame_controller: directed frames plus random frames, all checked every cycle
// against a frame-level model that interprets the bytes received since SS fell.
module tb_spi_frame_controller;

  localparam int unsigned M  = 320;
  localparam int unsigned N  = 8;
  localparam int unsigned AW = 9;

  logic          SCLK = 1'b0;
  logic          RESET, SS, rx_valid;
  logic [N-1:0]  rx_byte;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_data;
  logic          clk_div_ready_reg_out, debug_config_ready_reg_out, input_spike_ready_reg_out;
  logic [N-1:0]  tx_byte;
  logic          busy;

  spi_frame_controller #(.M(M), .N(N), .AW(AW)) dut (
    .SCLK                       (SCLK),
    .RESET                      (RESET),
    .SS                         (SS),
    .rx_valid                   (rx_valid),
    .rx_byte                    (rx_byte),
    .wr_en                      (wr_en),
    .wr_addr                    (wr_addr),
    .wr_data                    (wr_data),
    .clk_div_ready_reg_out      (clk_div_ready_reg_out),
    .debug_config_ready_reg_out (debug_config_ready_reg_out),
    .input_spike_ready_reg_out  (input_spike_ready_reg_out),
    .tx_byte                    (tx_byte),
    .busy                       (busy)
  );

  always #5 SCLK = ~SCLK;

  int n_checks = 0;
  int n_fail   = 0;
  int n_wr     = 0;

  // Reference model state
  logic [7:0]    frame[$];
  bit            m_wr_en;
  int            m_addr, m_data;
  bit [2:0]      m_rdy;
  bit            m_err;
  logic [7:0]    m_tx;
  bit            clr_pending;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_write_op(input logic [7:0] op);
    return (op == 8'hA1) || (op == 8'hA2) || (op == 8'hA3);
  endfunction

  function automatic int op_base(input logic [7:0] op);
    return (op == 8'hA1) ? 0 : (op == 8'hA2) ? 1 : 2;
  endfunction

  function automatic int op_len(input logic [7:0] op);
    return (op == 8'hA3) ? M - 2 : 1;
  endfunction

  task automatic model_step(input bit rst, input bit ss, input bit v, input logic [7:0] b);
    int k;
    m_wr_en = 1'b0;
    if (rst) begin
      frame.delete();
      m_addr = 0; m_data = 0; m_rdy = '0; m_err = 1'b0; m_tx = 8'h00; clr_pending = 1'b0;
      return;
    end
    if (clr_pending) begin
      m_err = 1'b0;
      clr_pending = 1'b0;
    end
    if (ss) begin
      if (frame.size() > 0 && is_write_op(frame[0]) && (frame.size() - 1) < op_len(frame[0]))
        m_err = 1'b1;
      frame.delete();
    end else if (v) begin
      frame.push_back(b);
      if (frame.size() == 1) begin
        if (is_write_op(b)) begin
          m_rdy[b - 8'hA1] = 1'b0;
        end else if (b == 8'hA4) begin
          m_tx = {4'b0000, m_err, m_rdy[2], m_rdy[1], m_rdy[0]};
          clr_pending = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end else if (is_write_op(frame[0])) begin
        k = frame.size() - 2;
        if (k < op_len(frame[0])) begin
          m_wr_en = 1'b1;
          m_addr  = op_base(frame[0]) + k;
          if (m_addr > M - 1) m_addr = M - 1;
          m_data  = b;
          if (k == op_len(frame[0]) - 1) m_rdy[frame[0] - 8'hA1] = 1'b1;
        end
      end
    end
  endtask

  task automatic tick(input bit rst, input bit ss, input bit v, input logic [7:0] b);
    RESET = rst; SS = ss; rx_valid = v; rx_byte = b;
    @(posedge SCLK);
    #1;
    model_step(rst, ss, v, b);
    check_eq("wr_en",     wr_en,                      m_wr_en);
    check_eq("wr_addr",   wr_addr,                    m_addr);
    check_eq("wr_data",   wr_data,                    m_data);
    check_eq("clkdiv_rdy", clk_div_ready_reg_out,     m_rdy[0]);
    check_eq("debug_rdy", debug_config_ready_reg_out, m_rdy[1]);
    check_eq("spike_rdy", input_spike_ready_reg_out,  m_rdy[2]);
    check_eq("tx_byte",   tx_byte,                    m_tx);
    check_eq("busy",      busy,                       frame.size() > 0);
    if (wr_en) n_wr++;
  endtask

  task automatic send(input logic [7:0] b);
    tick(1'b0, 1'b0, 1'b1, b);
  endtask

  task automatic end_frame();
    tick(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    int nb;
    logic [7:0] op;
    frame.delete();
    m_addr = 0; m_data = 0; m_rdy = '0; m_err = 1'b0; m_tx = 8'h00; clr_pending = 1'b0;
    m_wr_en = 1'b0;

    do_reset();
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_tx", tx_byte, 8'h00);

    // Single-byte CLKDIV frame
    send(8'hA1);
    send(8'h2F);
    check_eq("clkdiv_wr_en", wr_en, 1'b1);
    check_eq("clkdiv_addr", wr_addr, 0);
    check_eq("clkdiv_data", wr_data, 8'h2F);
    check_eq("clkdiv_flag", clk_div_ready_reg_out, 1'b1);
    end_frame();

    // Full SPIKE payload then overflow bytes
    n_wr = 0;
    send(8'hA3);
    for (int i = 0; i < int'(M) - 2; i++) send(8'(i));
    check_eq("spike_last_addr", wr_addr, M - 1);
    check_eq("spike_flag", input_spike_ready_reg_out, 1'b1);
    for (int i = 0; i < 3; i++) send(8'hEE);
    check_eq("spike_writes", n_wr, M - 2);
    end_frame();

    // Aborted SPIKE frame, then status readback
    do_reset();
    n_wr = 0;
    send(8'hA3);
    for (int i = 0; i < 10; i++) send(8'(8'h40 + i));
    end_frame();
    check_eq("abort_writes", n_wr, 10);
    check_eq("abort_last_addr", wr_addr, 11);
    check_eq("abort_flag", input_spike_ready_reg_out, 1'b0);
    send(8'hA4);
    check_eq("abort_status", tx_byte, 8'h08);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    end_frame();
    send(8'hA4);
    check_eq("err_cleared", tx_byte, 8'h00);
    end_frame();

    // Unknown opcode discards
    n_wr = 0;
    send(8'h55);
    send(8'hA1);
    send(8'h12);
    check_eq("bad_op_busy", busy, 1'b1);
    check_eq("bad_op_writes", n_wr, 0);
    end_frame();
    check_eq("bad_op_idle", busy, 1'b0);
    send(8'hA4);
    check_eq("bad_op_status", tx_byte, 8'h08);
    end_frame();

    // CLKDIV and DEBUG complete, status, then re-clear of CLKDIV
    do_reset();
    send(8'hA1); send(8'h11); end_frame();
    send(8'hA2); send(8'h22); end_frame();
    send(8'hA4);
    check_eq("both_status", tx_byte, 8'h03);
    end_frame();
    send(8'hA1);
    check_eq("reclear_flag", clk_div_ready_reg_out, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    check_eq("reclear_hold", clk_div_ready_reg_out, 1'b0);
    send(8'h33);
    check_eq("reclear_set", clk_div_ready_reg_out, 1'b1);
    end_frame();

    // Reset in the middle of a SPIKE payload
    send(8'hA3);
    for (int i = 0; i < 20; i++) send(8'(i));
    tick(1'b1, 1'b0, 1'b1, 8'h77);
    check_eq("rst_wr_en", wr_en, 1'b0);
    check_eq("rst_addr", wr_addr, 0);
    check_eq("rst_busy", busy, 1'b0);
    n_wr = 0;
    for (int i = 0; i < 5; i++) send(8'(8'h10 + i));
    check_eq("post_rst_writes", n_wr, 0);
    end_frame();

    // Random frames
    for (int f = 0; f < 60; f++) begin
      case ($urandom_range(0, 4))
        0: op = 8'hA1;
        1: op = 8'hA2;
        2: op = 8'hA3;
        3: op = 8'hA4;
        default: op = 8'($urandom);
      endcase
      if (op == 8'hA3 && $urandom_range(0, 5) == 0) nb = M - 2 + $urandom_range(0, 2);
      else nb = $urandom_range(0, 12);
      if ($urandom_range(0, 3) == 0) tick(1'b0, 1'b0, 1'b0, 8'h00);
      send(op);
      for (int j = 0; j < nb; j++) begin
        if ($urandom_range(0, 3) == 0) tick(1'b0, 1'b0, 1'b0, 8'($urandom));
        tick($urandom_range(0, 80) == 0, 1'b0, 1'b1, 8'($urandom));
      end
      for (int j = 0; j < int'($urandom_range(1, 3)); j++)
        tick(1'b0, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
